// File: rtl/icache_pkg.sv
// Shared constants, tag field layout and refill FSM states for the I-cache
// refill engine.
package icache_pkg;
    localparam int LINE_WORDS = 4;
    localparam int BEAT_W     = $clog2(LINE_WORDS);
    localparam int TAG_W      = 15;

    localparam int TAG_HI = 14;
    localparam int TAG_LO = 3;
    localparam int AGE_HI = 2;
    localparam int AGE_LO = 1;
    localparam int VLD    = 0;
    localparam int TAG_FW = TAG_HI - TAG_LO + 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR4 = 3'b011;
    localparam logic [2:0] HBURST_WRAP4 = 3'b010;
    localparam logic [2:0] HSIZE_WORD   = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BURST,
        ST_LAST,
        ST_WRITE,
        ST_DONE
    } refill_state_e;
endpackage

// File: rtl/icache_lru_sel.sv
// Victim selection and LRU age update for one 4-way set: first invalid way,
// otherwise the way whose age is 3. Purely combinational.
module icache_lru_sel
    import icache_pkg::*;
(
    input  logic [3:0][TAG_W-1:0] tags_i,
    input  logic [TAG_FW-1:0]     new_tag_i,
    output logic [3:0]            victim_oh_o,
    output logic [3:0][TAG_W-1:0] tags_o
);
    logic [1:0] victim;
    logic       found_invalid;
    logic [1:0] victim_age;

    always_comb begin
        victim        = 2'd0;
        found_invalid = 1'b0;
        // Descending scan so the lowest matching index wins.
        for (int i = 3; i >= 0; i--) begin
            if (!tags_i[i][VLD]) begin
                victim        = 2'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 3; i >= 0; i--) begin
                if (tags_i[i][AGE_HI:AGE_LO] == 2'd3) begin
                    victim = 2'(i);
                end
            end
        end

        victim_oh_o = 4'b0001 << victim;
        victim_age  = tags_i[victim][AGE_HI:AGE_LO];

        for (int i = 0; i < 4; i++) begin
            tags_o[i] = tags_i[i];
            if (victim == 2'(i)) begin
                tags_o[i] = {new_tag_i, 2'b00, 1'b1};
            end else if (tags_i[i][AGE_HI:AGE_LO] < victim_age) begin
                tags_o[i][AGE_HI:AGE_LO] = tags_i[i][AGE_HI:AGE_LO] + 2'd1;
            end
        end
    end
endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill engine: LRU victim pick, 4-beat AHB-Lite line fetch,
// tag/data write-back. Define ICACHE_CWF_EN for critical-word-first WRAP4 fetch.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              miss,
    input  logic [17:0]       miss_addr,
    input  logic [TAG_W-1:0]  way0_tag,
    input  logic [TAG_W-1:0]  way1_tag,
    input  logic [TAG_W-1:0]  way2_tag,
    input  logic [TAG_W-1:0]  way3_tag,
    output logic              miss_tag_En,
    output logic [TAG_W-1:0]  wd_tag0,
    output logic [TAG_W-1:0]  wd_tag1,
    output logic [TAG_W-1:0]  wd_tag2,
    output logic [TAG_W-1:0]  wd_tag3,
    output logic              miss_data_En0,
    output logic              miss_data_En1,
    output logic              miss_data_En2,
    output logic              miss_data_En3,
    output logic [127:0]      wdata,
    output logic              data3_valid,
    output logic [17:0]       last_addr,
    output logic              done,
    output logic              refill_err,
    output logic              refill_busy,
    output logic [1:0]        m_htrans,
    output logic [19:0]       m_haddr,
    output logic [2:0]        m_hburst,
    output logic [2:0]        m_hsize,
    output logic              m_hwrite,
    input  logic              m_hready,
    input  logic [31:0]       m_hrdata,
    input  logic              m_hresp
);
    refill_state_e         state_q, state_d;
    logic [17:0]           addr_q, addr_d;
    logic [3:0][TAG_W-1:0] tags_q, tags_d;
    logic [127:0]          line_q, line_d;
    logic [BEAT_W-1:0]     acnt_q, acnt_d;
    logic [BEAT_W-1:0]     dcnt_q, dcnt_d;
    logic                  err_q, err_d;

    logic [BEAT_W-1:0]     start_w;
    logic [BEAT_W-1:0]     addr_w;
    logic [BEAT_W-1:0]     slot_w;
    logic [2:0]            burst_type;
    logic [3:0]            victim_oh;
    logic [3:0][TAG_W-1:0] upd_tags;
    logic [3:0]            data_en;
    logic [3:0][TAG_W-1:0] wd_tags;

`ifdef ICACHE_CWF_EN
    assign start_w    = addr_q[1:0];
    assign burst_type = HBURST_WRAP4;
`else
    assign start_w    = '0;
    assign burst_type = HBURST_INCR4;
`endif

    // Beat words wrap modulo the line, so both builds share one datapath.
    assign addr_w = start_w + acnt_q;
    assign slot_w = start_w + dcnt_q;

    icache_lru_sel u_lru_sel (
        .tags_i      (tags_q),
        .new_tag_i   (addr_q[17:6]),
        .victim_oh_o (victim_oh),
        .tags_o      (upd_tags)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tags_d  = tags_q;
        line_d  = line_q;
        acnt_d  = acnt_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    addr_d  = miss_addr;
                    tags_d  = {way3_tag, way2_tag, way1_tag, way0_tag};
                    acnt_d  = '0;
                    dcnt_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_hready) begin
                    acnt_d  = acnt_q + 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (m_hresp) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (m_hready) begin
                    line_d[{~slot_w, 5'b0} +: 32] = m_hrdata;
                    dcnt_d = dcnt_q + 1'b1;
                    acnt_d = acnt_q + 1'b1;
                    if (acnt_q == 2'd3) begin
                        state_d = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                if (m_hresp) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (m_hready) begin
                    line_d[{~slot_w, 5'b0} +: 32] = m_hrdata;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            tags_q  <= '0;
            line_q  <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tags_q  <= tags_d;
            line_q  <= line_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
        end
    end

    // Bus and write-back outputs decode straight from state, so an async
    // reset drops HTRANS to IDLE without waiting for a clock.
    always_comb begin
        m_htrans    = HTRANS_IDLE;
        m_haddr     = '0;
        m_hburst    = '0;
        miss_tag_En = 1'b0;
        data3_valid = 1'b0;
        data_en     = '0;
        wd_tags     = '0;
        done        = 1'b0;
        refill_err  = 1'b0;
        case (state_q)
            ST_ADDR: begin
                m_htrans = HTRANS_NONSEQ;
                m_haddr  = {addr_q[17:2], addr_w, 2'b00};
                m_hburst = burst_type;
            end
            ST_BURST: begin
                m_htrans = HTRANS_SEQ;
                m_haddr  = {addr_q[17:2], addr_w, 2'b00};
                m_hburst = burst_type;
            end
            ST_WRITE: begin
                miss_tag_En = 1'b1;
                data3_valid = 1'b1;
                data_en     = victim_oh;
                wd_tags     = upd_tags;
            end
            ST_DONE: begin
                done       = 1'b1;
                refill_err = err_q;
            end
            default: ;
        endcase
    end

    assign refill_busy   = (state_q != ST_IDLE);
    assign m_hsize       = HSIZE_WORD;
    assign m_hwrite      = 1'b0;
    assign wdata         = line_q;
    assign last_addr     = addr_q;
    assign wd_tag0       = wd_tags[0];
    assign wd_tag1       = wd_tags[1];
    assign wd_tag2       = wd_tags[2];
    assign wd_tag3       = wd_tags[3];
    assign miss_data_En0 = data_en[0];
    assign miss_data_En1 = data_en[1];
    assign miss_data_En2 = data_en[2];
    assign miss_data_En3 = data_en[3];
endmodule
